// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous PWM
// input, recovers the generator set value, and flags inputs that stop toggling.
module pwm_capture #(
  parameter int CNT_WIDTH  = 16,
  parameter int DUTY_WIDTH = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pwm_in,
  output logic [CNT_WIDTH-1:0]  high_cycles,
  output logic [CNT_WIDTH-1:0]  period_cycles,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  valid,
  output logic                  stuck
);
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [DUTY_WIDTH-1:0] DUTY_MAX = '1;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d, s_q, s_d, s_dly_q, s_dly_d;
  logic [1:0]            mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, hlen_q, hlen_d;
  logic [CNT_WIDTH-1:0]  high_q, high_d, period_q, period_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic                  valid_q, valid_d, stuck_q, stuck_d;
  logic                  edge_en, rise, fall, timeout, publish;

  function automatic logic [DUTY_WIDTH-1:0] sat_duty(input logic [CNT_WIDTH-1:0] hlen);
    logic [CNT_WIDTH-1:0] set_val;
    set_val = hlen - CNT_ONE;
    if (set_val > CNT_WIDTH'(DUTY_MAX)) return DUTY_MAX;
    return set_val[DUTY_WIDTH-1:0];
  endfunction

  // Edges stay masked until the synchroniser has flushed its reset zeros,
  // so a pin that is already high at reset release is not taken as a rise.
  always_comb begin
    sync1_d = pwm_in;
    s_d     = sync1_q;
    s_dly_d = s_q;
    mask_d  = (mask_q == 2'd3) ? mask_q : mask_q + 2'd1;
  end

  assign edge_en = (mask_q == 2'd3);
  assign rise    = edge_en & s_q & ~s_dly_q;
  assign fall    = edge_en & ~s_q & s_dly_q;
  assign timeout = ~stuck_q & (cnt_q == TO_LAST) & ~rise & ~fall;
  assign publish = (state_q == LOW) & rise;

  always_comb begin
    cnt_d = cnt_q;
    if (rise)                          cnt_d = CNT_ONE;
    else if (!stuck_q && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_comb begin
    hlen_d = hlen_q;
    if (state_q == HIGH && fall) hlen_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = IDLE;
      endcase
    end
  end

  // A rise or fall never coincides with a timeout, so publish and timeout are exclusive.
  always_comb begin
    high_d   = high_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    if (publish) begin
      period_d = cnt_q;
      high_d   = hlen_q;
      duty_d   = sat_duty(hlen_q);
      valid_d  = 1'b1;
    end else if (timeout) begin
      period_d = '0;
      high_d   = '0;
      duty_d   = s_q ? DUTY_MAX : '0;
      valid_d  = 1'b1;
      stuck_d  = 1'b1;
    end
    if (rise || fall) stuck_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      s_dly_q  <= 1'b0;
      mask_q   <= 2'd0;
      cnt_q    <= '0;
      hlen_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      s_q      <= s_d;
      s_dly_q  <= s_dly_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      hlen_q   <= hlen_d;
      high_q   <= high_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign high_cycles   = high_q;
  assign period_cycles = period_q;
  assign duty          = duty_q;
  assign valid         = valid_q;
  assign stuck         = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: waveforms described as (high, low) segment lists,
// expected publishes derived from the segment arithmetic, strobes logged by a monitor.
module tb_pwm_capture;
  localparam int CW = 16;
  localparam int DW = 10;
  localparam int TO = 4096;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pwm_in;
  logic [CW-1:0] high_cycles, period_cycles;
  logic [DW-1:0] duty;
  logic          valid, stuck;

  pwm_capture #(.CNT_WIDTH(CW), .DUTY_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
    .high_cycles(high_cycles), .period_cycles(period_cycles),
    .duty(duty), .valid(valid), .stuck(stuck)
  );

  always #10 clk = ~clk;

  typedef struct {int cyc; int per; int hi; int dt; bit st;} rec_t;
  typedef struct {int per; int hi; int dt;} exp_t;

  int   cyc = 0;
  int   vec = 0;
  int   err = 0;
  rec_t got[$];
  rec_t mon_r;
  exp_t exp_q[$];
  exp_t e;
  int   seg_h[$];
  int   seg_l[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.per = int'(period_cycles);
      mon_r.hi  = int'(high_cycles);
      mon_r.dt  = int'(duty);
      mon_r.st  = stuck;
      got.push_back(mon_r);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic level);
    reset_n = 1'b0;
    pwm_in  = level;
    tick(3);
    reset_n = 1'b1;
  endtask

  // Each segment is one full period starting on a rise; a closing rise publishes the last one.
  task automatic drive_segments();
    for (int i = 0; i < seg_h.size(); i++) begin
      pwm_in = 1'b1;
      tick(seg_h[i]);
      pwm_in = 1'b0;
      tick(seg_l[i]);
    end
    pwm_in = 1'b1;
    tick(6);
  endtask

  task automatic model_expected();
    exp_q.delete();
    for (int i = 0; i < seg_h.size(); i++) begin
      e.per = seg_h[i] + seg_l[i];
      e.hi  = seg_h[i];
      e.dt  = (seg_h[i] - 1 > 1023) ? 1023 : seg_h[i] - 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_segments(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      seg_h.push_back(h);
      seg_l.push_back(l);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    tick(2);
    vec++; if (valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", valid); end
    vec++; if (stuck !== 1'b0) begin err++; $display("FAIL reset_stuck: got %b want 0", stuck); end
    vec++; if (duty !== '0) begin err++; $display("FAIL reset_duty: got %0d want 0", duty); end
    vec++; if (high_cycles !== '0) begin err++; $display("FAIL reset_high: got %0d want 0", high_cycles); end
    vec++; if (period_cycles !== '0) begin err++; $display("FAIL reset_period: got %0d want 0", period_cycles); end
  endtask

  task automatic test_waveforms();
    string nm;
    for (int sc = 0; sc < 7; sc++) begin
      seg_h.delete();
      seg_l.delete();
      case (sc)
        0: set_segments(4, 512, 512);
        1: set_segments(3, 1, 1023);
        2: begin set_segments(2, 512, 512); set_segments(2, 400, 400); end
        3: set_segments(2, 1500, 500);
        default: for (int i = 0; i < 3; i++) begin
          seg_h.push_back(int'($urandom_range(1500, 1)));
          seg_l.push_back(int'($urandom_range(600, 1)));
        end
      endcase
      nm = $sformatf("wave%0d", sc);
      model_expected();
      apply_reset(1'b0);
      tick(10);
      got.delete();
      drive_segments();
      vec++;
      if (got.size() !== exp_q.size()) begin
        err++; $display("FAIL %s_count: got %0d strobes want %0d", nm, got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        vec++;
        if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi ||
            got[i].dt !== exp_q[i].dt || got[i].st !== 1'b0) begin
          err++;
          $display("FAIL %s_rec%0d: got per=%0d hi=%0d duty=%0d stuck=%0d want per=%0d hi=%0d duty=%0d stuck=0",
                   nm, i, got[i].per, got[i].hi, got[i].dt, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].dt);
        end
        if (i > 0) begin
          vec++;
          if (got[i].cyc - got[i-1].cyc !== exp_q[i].per) begin
            err++; $display("FAIL %s_spacing%0d: got %0d cycles want %0d", nm, i, got[i].cyc - got[i-1].cyc, exp_q[i].per);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    tick(10);
    got.delete();
    seg_h.delete(); seg_l.delete();
    set_segments(1, 700, 324);
    drive_segments();
    tick(300);
    vec++;
    if (got.size() !== 1 || (got.size() == 1 && got[0].hi !== 700)) begin
      err++; $display("FAIL midrst_pre: got %0d strobes want 1 with high 700", got.size());
    end
    reset_n = 1'b0;
    #1;
    vec++;
    if (valid !== 1'b0 || stuck !== 1'b0 || duty !== '0 || high_cycles !== '0 || period_cycles !== '0) begin
      err++; $display("FAIL midrst_async: got valid=%b stuck=%b duty=%0d high=%0d period=%0d want all 0",
                      valid, stuck, duty, high_cycles, period_cycles);
    end
    tick(2);
    reset_n = 1'b1;
    got.delete();
    tick(398);
    pwm_in = 1'b0;
    tick(324);
    seg_h.delete(); seg_l.delete();
    set_segments(2, 700, 324);
    model_expected();
    drive_segments();
    vec++;
    if (got.size() !== 2) begin
      err++; $display("FAIL midrst_count: got %0d strobes want 2", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vec++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].dt !== exp_q[i].dt) begin
        err++; $display("FAIL midrst_rec%0d: got per=%0d hi=%0d duty=%0d want per=%0d hi=%0d duty=%0d",
                        i, got[i].per, got[i].hi, got[i].dt, exp_q[i].per, exp_q[i].hi, exp_q[i].dt);
      end
    end
  endtask

  task automatic test_stuck(input logic level);
    int    rel;
    int    want_dt;
    string nm;
    nm      = level ? "stuckhi" : "stucklo";
    want_dt = level ? 1023 : 0;
    apply_reset(level);
    rel = cyc;
    got.delete();
    tick(TO + 10);
    vec++;
    if (got.size() !== 1) begin
      err++; $display("FAIL %s_count: got %0d strobes want 1", nm, got.size());
    end else begin
      vec++;
      if (got[0].per !== 0 || got[0].hi !== 0 || got[0].dt !== want_dt || got[0].st !== 1'b1) begin
        err++; $display("FAIL %s_rec: got per=%0d hi=%0d duty=%0d stuck=%0d want per=0 hi=0 duty=%0d stuck=1",
                        nm, got[0].per, got[0].hi, got[0].dt, got[0].st, want_dt);
      end
      vec++;
      if (got[0].cyc - rel !== TO) begin
        err++; $display("FAIL %s_time: got strobe %0d cycles after release want %0d", nm, got[0].cyc - rel, TO);
      end
    end
    vec++; if (stuck !== 1'b1) begin err++; $display("FAIL %s_level: got stuck=%b want 1", nm, stuck); end
    seg_h.delete(); seg_l.delete();
    if (level) begin
      pwm_in = 1'b0;
      tick(20);
      vec++; if (stuck !== 1'b0) begin err++; $display("FAIL %s_clear: got stuck=%b want 0", nm, stuck); end
      vec++;
      if (got.size() !== 1 || duty !== 10'd1023 || period_cycles !== '0) begin
        err++; $display("FAIL %s_hold: got %0d strobes duty=%0d period=%0d want 1 strobe duty=1023 period=0",
                        nm, got.size(), duty, period_cycles);
      end
      set_segments(2, 300, 724);
    end else begin
      set_segments(2, 1500, 500);
    end
    model_expected();
    got.delete();
    drive_segments();
    vec++; if (stuck !== 1'b0) begin err++; $display("FAIL %s_after: got stuck=%b want 0", nm, stuck); end
    vec++;
    if (got.size() !== 2) begin
      err++; $display("FAIL %s_resume_count: got %0d strobes want 2", nm, got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      vec++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].dt !== exp_q[i].dt) begin
        err++; $display("FAIL %s_resume%0d: got per=%0d hi=%0d duty=%0d want per=%0d hi=%0d duty=%0d",
                        nm, i, got[i].per, got[i].hi, got[i].dt, exp_q[i].per, exp_q[i].hi, exp_q[i].dt);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    test_reset();
    test_waveforms();
    test_reset_mid();
    test_stuck(1'b1);
    test_stuck(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
